// File: rtl/rc5_key_schedule_pkg.sv
// Shared constants, size helpers and state encoding for the RC5 key-expansion engine.
package rc5_key_schedule_pkg;

  typedef enum logic [2:0] {StIdle, StLoadL, StInitS, StMix, StDone} state_e;

  function automatic int unsigned rc5_u(input int unsigned w);
    return w / 8;
  endfunction

  function automatic int unsigned rc5_c(input int unsigned w, input int unsigned b);
    int unsigned c;
    c = (b + rc5_u(w) - 1) / rc5_u(w);
    return (c == 0) ? 1 : c;
  endfunction

  function automatic int unsigned rc5_t(input int unsigned r);
    return 2 * (r + 1);
  endfunction

  function automatic int unsigned rc5_n(input int unsigned w, input int unsigned b,
                                        input int unsigned r);
    return (rc5_t(r) > rc5_c(w, b)) ? rc5_t(r) : rc5_c(w, b);
  endfunction

  function automatic logic [63:0] rc5_pw(input int unsigned w);
    case (w)
      16:      return 64'h0000_0000_0000_B7E1;
      32:      return 64'h0000_0000_B7E1_5163;
      default: return 64'hB7E1_5162_8AED_2A6B;
    endcase
  endfunction

  function automatic logic [63:0] rc5_qw(input int unsigned w);
    case (w)
      16:      return 64'h0000_0000_0000_9E37;
      32:      return 64'h0000_0000_9E37_79B9;
      default: return 64'h9E37_79B9_7F4A_7C15;
    endcase
  endfunction

endpackage

// File: rtl/rc5_key_schedule_if.sv
// Key-write, start and S-table read signals of the RC5 key-expansion engine.
interface rc5_key_schedule_if
  import rc5_key_schedule_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned B = 16,
  parameter int unsigned R = 12
) ();
  localparam int unsigned KW = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned SW = $clog2(rc5_t(R));

  logic [7:0]    iKey_sub_i;
  logic [KW-1:0] iKey_address;
  logic          iWen;
  logic          iStart;
  logic [SW-1:0] iS_addr;
  logic [W-1:0]  oS_data;
  logic          oBusy;
  logic          oDone;
  logic          oValid;

  modport master (
    output iKey_sub_i, iKey_address, iWen, iStart, iS_addr,
    input  oS_data, oBusy, oDone, oValid
  );

  modport slave (
    input  iKey_sub_i, iKey_address, iWen, iStart, iS_addr,
    output oS_data, oBusy, oDone, oValid
  );
endinterface

// File: rtl/rc5_rotl.sv
// Combinational left-rotate of a W-bit word by a variable amount (shared with the cipher paths).
module rc5_rotl #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]         i_data,
  input  logic [$clog2(W)-1:0] i_amt,
  output logic [W-1:0]         o_data
);
  logic [2*W-1:0] w_dbl;

  always_comb begin
    w_dbl  = {i_data, i_data} << i_amt;
    o_data = w_dbl[2*W-1 -: W];
  end
endmodule

// File: rtl/rc5_key_schedule.sv
// RC5-W/R/B key expansion: LOAD_L, INIT_S, 3*max(T,C) MIX, registered S read port.
// RC5_KEY_ZEROIZE_EN clears key bytes, L, A and B in the DONE cycle.
module rc5_key_schedule
  import rc5_key_schedule_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned B = 16,
  parameter int unsigned R = 12
) (
  input logic              clk,
  input logic              rst,
  rc5_key_schedule_if.slave bus
);
  localparam int unsigned U  = rc5_u(W);
  localparam int unsigned C  = rc5_c(W, B);
  localparam int unsigned T  = rc5_t(R);
  localparam int unsigned N  = rc5_n(W, B, R);
  localparam int unsigned AW = $clog2(W);
  localparam int unsigned IW = $clog2(T);
  localparam int unsigned JW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned MW = $clog2(3 * N);
  localparam logic [W-1:0] PW = W'(rc5_pw(W));
  localparam logic [W-1:0] QW = W'(rc5_qw(W));

  state_e        r_state;
  logic [7:0]    r_key [B];
  logic [W-1:0]  r_l [C];
  logic [W-1:0]  r_s [T];
  logic [IW-1:0] r_i;
  logic [JW-1:0] r_j;
  logic [MW-1:0] r_cnt;
  logic [W-1:0]  r_a, r_b, r_s_data;
  logic          r_busy, r_done, r_valid;

  logic [W-1:0]  w_l_word, w_a_sum, w_a_new, w_ab, w_b_sum, w_b_new;
  logic          w_wr_ok, w_i_last, w_j_last;

  assign w_wr_ok  = bus.iWen && !r_busy && (int'(bus.iKey_address) < B);
  assign w_i_last = (r_i == IW'(T - 1));
  assign w_j_last = (r_j == JW'(C - 1));

  // Little-endian packing of bytes jU..jU+U-1; bytes past B stay zero.
  always_comb begin
    w_l_word = '0;
    for (int k = 0; k < B; k++) begin
      if (k / U == int'(r_j)) w_l_word[8*(k%U) +: 8] = r_key[k];
    end
  end

  always_comb begin
    w_a_sum = r_s[r_i] + r_a + r_b;
    w_ab    = w_a_new + r_b;
    w_b_sum = r_l[r_j] + w_ab;
  end

  rc5_rotl #(.W(W)) u_rotl_a (
    .i_data (w_a_sum),
    .i_amt  (AW'(3)),
    .o_data (w_a_new)
  );

  rc5_rotl #(.W(W)) u_rotl_b (
    .i_data (w_b_sum),
    .i_amt  (w_ab[AW-1:0]),
    .o_data (w_b_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_i      <= '0;
      r_j      <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_s_data <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_s_data <= (int'(bus.iS_addr) < T) ? r_s[bus.iS_addr] : '0;
      unique case (r_state)
        StIdle: begin
          if (w_wr_ok) r_valid <= 1'b0;
          if (bus.iStart) begin
            r_state <= StLoadL;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_j     <= '0;
          end
        end
        StLoadL: begin
          if (w_j_last) begin
            r_j     <= '0;
            r_i     <= '0;
            r_state <= StInitS;
          end else begin
            r_j <= r_j + JW'(1);
          end
        end
        StInitS: begin
          if (w_i_last) begin
            r_i     <= '0;
            r_j     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_state <= StMix;
          end else begin
            r_i <= r_i + IW'(1);
          end
        end
        StMix: begin
          r_a <= w_a_new;
          r_b <= w_b_new;
          r_i <= w_i_last ? '0 : r_i + IW'(1);
          r_j <= w_j_last ? '0 : r_j + JW'(1);
          if (r_cnt == MW'(3 * N - 1)) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + MW'(1);
          end
        end
        StDone: begin
          r_state <= StIdle;
          if (w_wr_ok) r_valid <= 1'b0;
`ifdef RC5_KEY_ZEROIZE_EN
          r_a <= '0;
          r_b <= '0;
`endif
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Storage is deliberately unreset; a write in the DONE cycle overrides zeroization.
  always_ff @(posedge clk) begin
`ifdef RC5_KEY_ZEROIZE_EN
    if (r_state == StDone) begin
      for (int k = 0; k < B; k++) r_key[k] <= '0;
      for (int k = 0; k < C; k++) r_l[k] <= '0;
    end
`endif
    if (w_wr_ok && !rst) r_key[bus.iKey_address] <= bus.iKey_sub_i;
    if (r_state == StLoadL) r_l[r_j] <= w_l_word;
    if (r_state == StInitS) r_s[r_i] <= (r_i == '0) ? PW : r_s[r_i - IW'(1)] + QW;
    if (r_state == StMix) begin
      r_s[r_i] <= w_a_new;
      r_l[r_j] <= w_b_new;
    end
  end

  assign bus.oS_data = r_s_data;
  assign bus.oBusy   = r_busy;
  assign bus.oDone   = r_done;
  assign bus.oValid  = r_valid;
endmodule

// File: tb/tb_rc5_key_schedule.sv
// Directed bench: default RC5-32/12/16 engine checked via known cipher vectors, plus W=16,B=1,R=0.
module tb_rc5_key_schedule;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rc5_key_schedule_if #(.W(32), .B(16), .R(12)) bus ();
  rc5_key_schedule_if #(.W(16), .B(1), .R(0)) sbus ();

  rc5_key_schedule #(.W(32), .B(16), .R(12)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rc5_key_schedule #(.W(16), .B(1), .R(0)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  logic [31:0] s_tab  [26];
  logic [31:0] s_zero [26];
  logic [31:0] s_key  [26];
  logic [31:0] s_exp  [26];
  logic [7:0]  key2   [16];

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [31:0] n);
    int s;
    s = int'(n[4:0]);
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [31:0] n);
    int s;
    s = int'(n[4:0]);
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic void rc5_enc(input logic [31:0] pa, input logic [31:0] pb,
                                  output logic [31:0] ca, output logic [31:0] cb);
    logic [31:0] a, b;
    a = pa + s_tab[0];
    b = pb + s_tab[1];
    for (int r = 1; r <= 12; r++) begin
      a = rotl32(a ^ b, b) + s_tab[2*r];
      b = rotl32(b ^ a, a) + s_tab[2*r+1];
    end
    ca = a;
    cb = b;
  endfunction

  function automatic void rc5_dec(input logic [31:0] ca, input logic [31:0] cb,
                                  output logic [31:0] pa, output logic [31:0] pb);
    logic [31:0] a, b;
    a = ca;
    b = cb;
    for (int r = 12; r >= 1; r--) begin
      b = rotr32(b - s_tab[2*r+1], a) ^ a;
      a = rotr32(a - s_tab[2*r], b) ^ b;
    end
    pb = b - s_tab[1];
    pa = a - s_tab[0];
  endfunction

  task automatic write_key(input int a, input logic [7:0] d);
    @(negedge clk);
    bus.iWen         = 1'b1;
    bus.iKey_address = 4'(a);
    bus.iKey_sub_i   = d;
    @(negedge clk);
    bus.iWen = 1'b0;
  endtask

  task automatic read_table();
    for (int a = 0; a < 26; a++) begin
      @(negedge clk);
      bus.iS_addr = 5'(a);
      @(negedge clk);
      s_tab[a] = bus.oS_data;
    end
  endtask

  // Pulses iStart (optionally with a byte-0 write), optionally pokes iWen+iStart mid-run,
  // and measures busy length, done pulses and the done-to-busy-fall gap.
  task automatic expand(input int inject_at, input bit wr0, output int busy_n,
                        output int done_n, output int gap);
    int last_busy;
    int done_at;
    last_busy = -1;
    done_at   = -1;
    busy_n    = 0;
    done_n    = 0;
    @(negedge clk);
    bus.iStart = 1'b1;
    if (wr0) begin
      bus.iWen         = 1'b1;
      bus.iKey_address = 4'd0;
      bus.iKey_sub_i   = key2[0];
    end
    @(negedge clk);
    bus.iStart = 1'b0;
    bus.iWen   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.oBusy) begin
        busy_n++;
        last_busy = c;
      end
      if (bus.oDone) begin
        done_n++;
        done_at = c;
      end
      if (c == inject_at) begin
        bus.iWen         = 1'b1;
        bus.iKey_address = 4'd0;
        bus.iKey_sub_i   = 8'hAA;
        bus.iStart       = 1'b1;
      end else begin
        bus.iWen   = 1'b0;
        bus.iStart = 1'b0;
      end
      if (done_n > 0 && c > done_at + 2) break;
      @(negedge clk);
    end
    bus.iWen   = 1'b0;
    bus.iStart = 1'b0;
    gap = done_at - last_busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iKey_sub_i = '0; bus.iKey_address = '0; bus.iWen = 1'b0;
    bus.iStart = 1'b0;   bus.iS_addr = '0;
    sbus.iKey_sub_i = '0; sbus.iKey_address = '0; sbus.iWen = 1'b0;
    sbus.iStart = 1'b0;   sbus.iS_addr = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.oBusy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.oBusy); end
    n_cmp++; if (bus.oDone !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.oDone); end
    n_cmp++; if (bus.oValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.oValid); end
    n_cmp++; if (bus.oS_data !== 32'h0) begin n_bad++; $display("FAIL reset_sdata: got %h want 0", bus.oS_data); end
    n_cmp++; if (sbus.oBusy !== 1'b0) begin n_bad++; $display("FAIL reset_small_busy: got %b want 0", sbus.oBusy); end
    n_cmp++; if (sbus.oValid !== 1'b0) begin n_bad++; $display("FAIL reset_small_valid: got %b want 0", sbus.oValid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_small_config();
    int busy_n, done_n, last_busy, done_at;
    logic [15:0] got;
    busy_n = 0; done_n = 0; last_busy = -1; done_at = -1;
    @(negedge clk);
    sbus.iWen = 1'b1; sbus.iKey_address = 1'b0; sbus.iKey_sub_i = 8'h00;
    @(negedge clk);
    sbus.iWen = 1'b0; sbus.iStart = 1'b1;
    @(negedge clk);
    sbus.iStart = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sbus.oBusy) begin busy_n++; last_busy = c; end
      if (sbus.oDone) begin done_n++; done_at = c; end
      if (done_n > 0 && c > done_at + 2) break;
      @(negedge clk);
    end
    n_cmp++; if (busy_n != 9) begin n_bad++; $display("FAIL small_busy_len: got %0d want 9", busy_n); end
    n_cmp++; if (done_n != 1) begin n_bad++; $display("FAIL small_done_pulses: got %0d want 1", done_n); end
    n_cmp++; if (done_at - last_busy != 1) begin n_bad++; $display("FAIL small_done_gap: got %0d want 1", done_at - last_busy); end
    n_cmp++; if (sbus.oValid !== 1'b1) begin n_bad++; $display("FAIL small_valid: got %b want 1", sbus.oValid); end
    sbus.iS_addr = 1'b0;
    @(negedge clk);
    got = sbus.oS_data;
    n_cmp++; if (got !== 16'h7865) begin n_bad++; $display("FAIL small_s0: got %h want 7865", got); end
    sbus.iS_addr = 1'b1;
    @(negedge clk);
    got = sbus.oS_data;
    n_cmp++; if (got !== 16'h33F4) begin n_bad++; $display("FAIL small_s1: got %h want 33f4", got); end
    // Address 1 is out of range for B=1: dropped, so oValid must survive.
    sbus.iWen = 1'b1; sbus.iKey_address = 1'b1; sbus.iKey_sub_i = 8'hFF;
    @(negedge clk);
    sbus.iWen = 1'b0;
    n_cmp++; if (sbus.oValid !== 1'b1) begin n_bad++; $display("FAIL small_drop_keeps_valid: got %b want 1", sbus.oValid); end
    sbus.iWen = 1'b1; sbus.iKey_address = 1'b0; sbus.iKey_sub_i = 8'h00;
    @(negedge clk);
    sbus.iWen = 1'b0;
    n_cmp++; if (sbus.oValid !== 1'b0) begin n_bad++; $display("FAIL small_write_clears_valid: got %b want 0", sbus.oValid); end
  endtask

  task automatic test_latency_zero_key();
    int busy_n, done_n, gap;
    logic [31:0] ca, cb;
    for (int a = 0; a < 16; a++) write_key(a, 8'h00);
    expand(-1, 1'b0, busy_n, done_n, gap);
    n_cmp++; if (busy_n != 108) begin n_bad++; $display("FAIL zero_busy_len: got %0d want 108", busy_n); end
    n_cmp++; if (done_n != 1) begin n_bad++; $display("FAIL zero_done_pulses: got %0d want 1", done_n); end
    n_cmp++; if (gap != 1) begin n_bad++; $display("FAIL zero_done_gap: got %0d want 1", gap); end
    n_cmp++; if (bus.oValid !== 1'b1) begin n_bad++; $display("FAIL zero_valid: got %b want 1", bus.oValid); end
    read_table();
    rc5_enc(32'h0, 32'h0, ca, cb);
    n_cmp++; if (ca !== 32'hEEDBA521) begin n_bad++; $display("FAIL zero_enc_a: got %h want eedba521", ca); end
    n_cmp++; if (cb !== 32'h6D8F4B15) begin n_bad++; $display("FAIL zero_enc_b: got %h want 6d8f4b15", cb); end
    s_zero = s_tab;
  endtask

  task automatic test_s_addr_oob();
    @(negedge clk);
    bus.iS_addr = 5'd26;
    @(negedge clk);
    n_cmp++; if (bus.oS_data !== 32'h0) begin n_bad++; $display("FAIL oob_26: got %h want 0", bus.oS_data); end
    bus.iS_addr = 5'd31;
    @(negedge clk);
    n_cmp++; if (bus.oS_data !== 32'h0) begin n_bad++; $display("FAIL oob_31: got %h want 0", bus.oS_data); end
  endtask

  task automatic test_nonzero_key();
    int busy_n, done_n, gap;
    logic [31:0] ca, cb, pa, pb;
    write_key(0, key2[0]);
    n_cmp++; if (bus.oValid !== 1'b0) begin n_bad++; $display("FAIL wen_clears_valid: got %b want 0", bus.oValid); end
    for (int a = 1; a < 16; a++) write_key(a, key2[a]);
    expand(-1, 1'b0, busy_n, done_n, gap);
    n_cmp++; if (busy_n != 108) begin n_bad++; $display("FAIL key_busy_len: got %0d want 108", busy_n); end
    read_table();
    rc5_enc(32'hEEDBA521, 32'h6D8F4B15, ca, cb);
    n_cmp++; if (ca !== 32'hAC13C0F7) begin n_bad++; $display("FAIL key_enc_a: got %h want ac13c0f7", ca); end
    n_cmp++; if (cb !== 32'h52892B5B) begin n_bad++; $display("FAIL key_enc_b: got %h want 52892b5b", cb); end
    rc5_dec(32'hAC13C0F7, 32'h52892B5B, pa, pb);
    n_cmp++; if (pa !== 32'hEEDBA521) begin n_bad++; $display("FAIL key_dec_a: got %h want eedba521", pa); end
    n_cmp++; if (pb !== 32'h6D8F4B15) begin n_bad++; $display("FAIL key_dec_b: got %h want 6d8f4b15", pb); end
    s_key = s_tab;
  endtask

  task automatic test_busy_ignore();
    int busy_n, done_n, gap, diffs;
`ifdef RC5_KEY_ZEROIZE_EN
    s_exp = s_zero;
`else
    s_exp = s_key;
`endif
    expand(20, 1'b0, busy_n, done_n, gap);
    n_cmp++; if (busy_n != 108) begin n_bad++; $display("FAIL busy_start_ignored: got %0d want 108", busy_n); end
    n_cmp++; if (done_n != 1) begin n_bad++; $display("FAIL busy_done_pulses: got %0d want 1", done_n); end
    read_table();
    diffs = 0;
    for (int a = 0; a < 26; a++) begin
      n_cmp++;
      if (s_tab[a] !== s_exp[a]) begin
        n_bad++;
        diffs++;
        $display("FAIL busy_wen_ignored_s%0d: got %h want %h", a, s_tab[a], s_exp[a]);
      end
    end
  endtask

  task automatic test_simultaneous();
    int busy_n, done_n, gap;
    logic [31:0] ca, cb;
    write_key(0, 8'h00);
    for (int a = 1; a < 16; a++) write_key(a, key2[a]);
    expand(-1, 1'b1, busy_n, done_n, gap);
    n_cmp++; if (busy_n != 108) begin n_bad++; $display("FAIL simul_busy_len: got %0d want 108", busy_n); end
    read_table();
    rc5_enc(32'hEEDBA521, 32'h6D8F4B15, ca, cb);
    n_cmp++; if (ca !== 32'hAC13C0F7) begin n_bad++; $display("FAIL simul_enc_a: got %h want ac13c0f7", ca); end
    n_cmp++; if (cb !== 32'h52892B5B) begin n_bad++; $display("FAIL simul_enc_b: got %h want 52892b5b", cb); end
  endtask

  task automatic test_reset_mid_mix();
    int busy_n, done_n, gap;
    logic [31:0] ca, cb;
    for (int a = 0; a < 16; a++) write_key(a, key2[a]);
    @(negedge clk);
    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    repeat (50) @(negedge clk);
    n_cmp++; if (bus.oBusy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before_rst: got %b want 1", bus.oBusy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.oBusy !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy: got %b want 0", bus.oBusy); end
    n_cmp++; if (bus.oDone !== 1'b0) begin n_bad++; $display("FAIL async_rst_done: got %b want 0", bus.oDone); end
    n_cmp++; if (bus.oValid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got %b want 0", bus.oValid); end
    n_cmp++; if (bus.oS_data !== 32'h0) begin n_bad++; $display("FAIL async_rst_sdata: got %h want 0", bus.oS_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.oValid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid: got %b want 0", bus.oValid); end
    expand(-1, 1'b0, busy_n, done_n, gap);
    n_cmp++; if (busy_n != 108) begin n_bad++; $display("FAIL post_rst_busy_len: got %0d want 108", busy_n); end
    n_cmp++; if (done_n != 1) begin n_bad++; $display("FAIL post_rst_done_pulses: got %0d want 1", done_n); end
    read_table();
    rc5_enc(32'hEEDBA521, 32'h6D8F4B15, ca, cb);
    n_cmp++; if (ca !== 32'hAC13C0F7) begin n_bad++; $display("FAIL post_rst_enc_a: got %h want ac13c0f7", ca); end
    n_cmp++; if (cb !== 32'h52892B5B) begin n_bad++; $display("FAIL post_rst_enc_b: got %h want 52892b5b", cb); end
  endtask

  initial begin
    key2 = '{8'h91, 8'h5F, 8'h46, 8'h19, 8'hBE, 8'h41, 8'hB2, 8'h51,
             8'h63, 8'h55, 8'hA5, 8'h01, 8'h10, 8'hA9, 8'hCE, 8'h91};
    test_reset();
    test_small_config();
    test_latency_zero_key();
    test_s_addr_oob();
    test_nonzero_key();
    test_busy_ignore();
    test_simultaneous();
    test_reset_mid_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
